// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO that sits behind uart_rx,
// dropping bytes when full and flagging the loss in a sticky overflow bit.
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr, r_ptr;
    logic              push, pop;

    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push   = wr && (!full || rd);
    assign pop    = rd && !empty;
    assign r_data = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (push && reset)
            mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                w_ptr <= w_ptr + 1'b1;
            if (pop)
                r_ptr <= r_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
                empty <= 1'b0;
                full  <= (count == (ADDR_W+1)'(DEPTH - 1));
            end else if (pop && !push) begin
                count <= count - 1'b1;
                full  <= 1'b0;
                empty <= (count == (ADDR_W+1)'(1));
            end
            overflow <= (wr && !push) || (overflow && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed tests of uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset, wr, rd, clr_ovf;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, overflow;
    logic [4:0] count;
    int         total = 0;
    int         bad = 0;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr = 1'b1; w_data = b;
        step();
        wr = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0; w_data = '0;
        step(); step();
        reset = 1'b1;
        step();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);

        push(8'h35); push(8'hA5); push(8'h3C);
        chk("t2_count", count, 3);
        chk("t2_head0", r_data, 8'h35);
        chk("t2_nempty", empty, 0);
        pop();
        chk("t2_head1", r_data, 8'hA5);
        pop();
        chk("t2_head2", r_data, 8'h3C);
        chk("t2_count1", count, 1);
        pop();
        chk("t2_empty", empty, 1);
        chk("t2_count0", count, 0);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("t3_fill_count", count, i + 1);
            chk("t3_fill_full", full, (i == 15) ? 1 : 0);
        end
        push(8'hFF);
        chk("t3_ovf", overflow, 1);
        chk("t3_count16", count, 16);
        chk("t3_head_kept", r_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", r_data, i);
            pop();
            chk("t3_drain_full", full, 0);
        end
        chk("t3_empty", empty, 1);
        chk("t3_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("t3_ovf_clr", overflow, 0);

        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        chk("t4_full", full, 1);
        wr = 1'b1; w_data = 8'hEE; clr_ovf = 1'b1;
        step();
        wr = 1'b0; clr_ovf = 1'b0;
        chk("t4_set_wins", overflow, 1);
        chk("t4_set_count", count, 16);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("t4_clr", overflow, 0);
        wr = 1'b1; rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w_data = 8'h77 + 8'(i);
            step();
            chk("t4_rw_count", count, 16);
            chk("t4_rw_full", full, 1);
            chk("t4_rw_ovf", overflow, 0);
            chk("t4_rw_head", r_data, (i < 15) ? 8'h11 + i : 8'h77 + (i - 15));
        end
        wr = 1'b0; rd = 1'b0;
        for (int i = 4; i < 20; i++) begin
            chk("t4_drain", r_data, 8'h77 + i);
            pop();
        end
        chk("t4_empty", empty, 1);
        chk("t4_count0", count, 0);

        pop();
        chk("t5_rd_empty_count", count, 0);
        chk("t5_rd_empty_flag", empty, 1);
        chk("t5_rd_empty_ovf", overflow, 0);
        wr = 1'b1; rd = 1'b1; w_data = 8'h5A;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("t5_rw_count", count, 1);
        chk("t5_rw_data", r_data, 8'h5A);
        chk("t5_rw_empty", empty, 0);

        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        chk("t6_count5", count, 5);
        reset = 1'b0; wr = 1'b1; w_data = 8'h99;
        step();
        reset = 1'b1; wr = 1'b0;
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_full", full, 0);
        push(8'hC3);
        chk("t6_data", r_data, 8'hC3);
        chk("t6_count1", count, 1);
        pop();
        push(8'h55);
        chk("e2e_data", r_data, 8'h55);
        chk("e2e_empty", empty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
